// File: rtl/pong_pkg.sv
// Shared Pong constants: screen geometry, sprite sizes, reset positions and colours.
// Used by the renderer and by the game logic.
package pong_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned H_VIDEO    = 640;
  localparam int unsigned V_VIDEO    = 480;
  localparam int unsigned SQ_WIDTH   = 16;
  localparam int unsigned PDL_WIDTH  = 12;
  localparam int unsigned PDL_HEIGHT = 96;

  localparam logic [11:0] FG_RGB    = 12'hFFF;
  localparam logic [11:0] BG_RGB    = 12'h000;
  localparam logic [11:0] BLANK_RGB = 12'h000;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pos_t;

  localparam pos_t SQ_RST   = '{x: 10'd320, y: 10'd240};
  localparam pos_t PDL1_RST = '{x: 10'd24,  y: 10'd191};
  localparam pos_t PDL2_RST = '{x: 10'd603, y: 10'd191};

  typedef struct packed {
    logic sq;
    logic p1;
    logic p2;
    logic net;
  } hit_t;

  typedef enum logic [1:0] {
    SrcBg,
    SrcSq,
    SrcPdl,
    SrcNet
  } src_e;

  // Every sprite shares one colour; only the background differs.
  function automatic logic [11:0] src_color(src_e src, logic [11:0] fg, logic [11:0] bg);
    return (src == SrcBg) ? bg : fg;
  endfunction

endpackage

// File: rtl/pong_rect_hit.sv
// Combinational test of whether the current pixel lies inside a W x H rectangle.
// End coordinates are formed in 11 bits so sprites near the right/bottom edge never wrap.
module pong_rect_hit
  import pong_pkg::*;
#(
  parameter int unsigned W = SQ_WIDTH,
  parameter int unsigned H = SQ_WIDTH
) (
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit
);

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        h_in;
  logic        v_in;

  always_comb begin
    x_end = {1'b0, x} + 11'(W);
    y_end = {1'b0, y} + 11'(H);
    h_in  = (h_count >= x) && ({1'b0, h_count} < x_end);
    v_in  = (v_count >= y) && ({1'b0, v_count} < y_end);
    hit   = h_in && v_in;
  end

endmodule

// File: rtl/pong_renderer.sv
// Pong pixel renderer: tear-free position shadows, 2-stage hit/colour pipeline.
// Optional dashed centre net is enabled by defining PONG_CENTER_NET_EN.
module pong_renderer
  import pong_pkg::*;
#(
  parameter int unsigned H_VIDEO    = pong_pkg::H_VIDEO,
  parameter int unsigned V_VIDEO    = pong_pkg::V_VIDEO,
  parameter int unsigned SQ_WIDTH   = pong_pkg::SQ_WIDTH,
  parameter int unsigned PDL_WIDTH  = pong_pkg::PDL_WIDTH,
  parameter int unsigned PDL_HEIGHT = pong_pkg::PDL_HEIGHT,
  parameter logic [11:0] FG_RGB     = pong_pkg::FG_RGB,
  parameter logic [11:0] BG_RGB     = pong_pkg::BG_RGB
) (
  input  logic        clk_0,
  input  logic        rst,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        video_on,
  input  logic [9:0]  sq_xpos,
  input  logic [9:0]  sq_ypos,
  input  logic [9:0]  pdl1_xpos,
  input  logic [9:0]  pdl1_ypos,
  input  logic [9:0]  pdl2_xpos,
  input  logic [9:0]  pdl2_ypos,
  output logic [11:0] rgb,
  output logic        de_out
);

  // Shadow positions, only updated on the first pixel of the first blanking line.
  pos_t sq_q,   sq_d;
  pos_t pdl1_q, pdl1_d;
  pos_t pdl2_q, pdl2_d;
  logic latch;

  assign latch = (h_count == 10'd0) && (v_count == 10'(V_VIDEO));

  always_comb begin
    sq_d   = sq_q;
    pdl1_d = pdl1_q;
    pdl2_d = pdl2_q;
    if (latch) begin
      sq_d   = '{x: sq_xpos,   y: sq_ypos};
      pdl1_d = '{x: pdl1_xpos, y: pdl1_ypos};
      pdl2_d = '{x: pdl2_xpos, y: pdl2_ypos};
    end
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      sq_q   <= SQ_RST;
      pdl1_q <= PDL1_RST;
      pdl2_q <= PDL2_RST;
    end else begin
      sq_q   <= sq_d;
      pdl1_q <= pdl1_d;
      pdl2_q <= pdl2_d;
    end
  end

  hit_t hit_d, hit_q;
  logic video_on_q;

  pong_rect_hit #(
    .W (SQ_WIDTH),
    .H (SQ_WIDTH)
  ) u_sq_hit (
    .h_count (h_count),
    .v_count (v_count),
    .x       (sq_q.x),
    .y       (sq_q.y),
    .hit     (hit_d.sq)
  );

  pong_rect_hit #(
    .W (PDL_WIDTH),
    .H (PDL_HEIGHT)
  ) u_pdl1_hit (
    .h_count (h_count),
    .v_count (v_count),
    .x       (pdl1_q.x),
    .y       (pdl1_q.y),
    .hit     (hit_d.p1)
  );

  pong_rect_hit #(
    .W (PDL_WIDTH),
    .H (PDL_HEIGHT)
  ) u_pdl2_hit (
    .h_count (h_count),
    .v_count (v_count),
    .x       (pdl2_q.x),
    .y       (pdl2_q.y),
    .hit     (hit_d.p2)
  );

`ifdef PONG_CENTER_NET_EN
  // Two-pixel-wide net straddling the centre, dashed in 16-line segments.
  localparam logic [9:0] NET_L = 10'(H_VIDEO / 2 - 1);
  localparam logic [9:0] NET_R = 10'(H_VIDEO / 2);

  assign hit_d.net = ((h_count == NET_L) || (h_count == NET_R)) && !v_count[4];
`else
  assign hit_d.net = 1'b0;
`endif

  // Stage 1: hit flags and video_on.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      hit_q      <= '0;
      video_on_q <= 1'b0;
    end else begin
      hit_q      <= hit_d;
      video_on_q <= video_on;
    end
  end

  // Stage 2: priority select and blanking.
  src_e        src;
  logic [11:0] rgb_d, rgb_q;
  logic        de_q;

  always_comb begin
    src = SrcBg;
    if (hit_q.sq) begin
      src = SrcSq;
    end else if (hit_q.p1 || hit_q.p2) begin
      src = SrcPdl;
    end else if (hit_q.net) begin
      src = SrcNet;
    end
    rgb_d = video_on_q ? src_color(src, FG_RGB, BG_RGB) : BLANK_RGB;
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      rgb_q <= 12'h000;
      de_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      de_q  <= video_on_q;
    end
  end

  assign rgb    = rgb_q;
  assign de_out = de_q;

endmodule

// File: tb/tb_pong_renderer.sv
// Self-checking bench for pong_renderer: directed scenarios plus randomized pixels
// checked against a rectangle-geometry reference model with a 2-cycle output lag.
module tb_pong_renderer;

  logic        clk_0 = 1'b0;
  logic        rst;
  logic [9:0]  h_count, v_count;
  logic        video_on;
  logic [9:0]  sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos;
  logic [11:0] rgb;
  logic        de_out;

  always #20 clk_0 = ~clk_0;

  pong_renderer dut (
    .clk_0     (clk_0),
    .rst       (rst),
    .h_count   (h_count),
    .v_count   (v_count),
    .video_on  (video_on),
    .sq_xpos   (sq_xpos),
    .sq_ypos   (sq_ypos),
    .pdl1_xpos (pdl1_xpos),
    .pdl1_ypos (pdl1_ypos),
    .pdl2_xpos (pdl2_xpos),
    .pdl2_ypos (pdl2_ypos),
    .rgb       (rgb),
    .de_out    (de_out)
  );

  int total, bad;

  // Reference model state: positions the frame is being drawn with.
  int m_sq_x, m_sq_y, m_p1_x, m_p1_y, m_p2_x, m_p2_y;
  // Expected output for the most recent input and the one before it.
  logic [11:0] cur_rgb, lag_rgb;
  logic        cur_de, lag_de;
  int          cur_h, cur_v, lag_h, lag_v;

  function automatic bit in_rect(int h, int v, int x, int y, int w, int ht);
    return (h >= x) && (h < x + w) && (v >= y) && (v < y + ht);
  endfunction

  function automatic logic [11:0] model_rgb(int h, int v, bit vid);
    bit hit;
    if (!vid) return 12'h000;
    hit = in_rect(h, v, m_sq_x, m_sq_y, 16, 16) ||
          in_rect(h, v, m_p1_x, m_p1_y, 12, 96) ||
          in_rect(h, v, m_p2_x, m_p2_y, 12, 96);
`ifdef PONG_CENTER_NET_EN
    if ((h == 319 || h == 320) && ((v / 16) % 2 == 0)) hit = 1'b1;
`endif
    return hit ? 12'hFFF : 12'h000;
  endfunction

  task automatic model_reset();
    m_sq_x = 320; m_sq_y = 240;
    m_p1_x = 24;  m_p1_y = 191;
    m_p2_x = 603; m_p2_y = 191;
  endtask

  task automatic set_pos(input int sx, input int sy, input int p1x, input int p1y,
                         input int p2x, input int p2y);
    sq_xpos = 10'(sx);    sq_ypos = 10'(sy);
    pdl1_xpos = 10'(p1x); pdl1_ypos = 10'(p1y);
    pdl2_xpos = 10'(p2x); pdl2_ypos = 10'(p2y);
  endtask

  // Apply one pixel; afterwards rgb/de_out should match lag_rgb/lag_de.
  task automatic step(input int h, input int v, input bit vid);
    @(negedge clk_0);
    h_count = 10'(h); v_count = 10'(v); video_on = vid;
    lag_h = cur_h; lag_v = cur_v;
    if (!rst) begin
      lag_rgb = 12'h000; lag_de = 1'b0;
      cur_rgb = 12'h000; cur_de = 1'b0;
      model_reset();
    end else begin
      lag_rgb = cur_rgb; lag_de = cur_de;
      cur_rgb = model_rgb(h, v, vid);
      cur_de  = vid;
      if (h == 0 && v == 480) begin
        m_sq_x = int'(sq_xpos);   m_sq_y = int'(sq_ypos);
        m_p1_x = int'(pdl1_xpos); m_p1_y = int'(pdl1_ypos);
        m_p2_x = int'(pdl2_xpos); m_p2_y = int'(pdl2_ypos);
      end
    end
    cur_h = h; cur_v = v;
    @(posedge clk_0);
    #1;
  endtask

  task automatic test_reset();
    set_pos($urandom_range(1023), $urandom_range(1023), $urandom_range(1023),
            $urandom_range(1023), $urandom_range(1023), $urandom_range(1023));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step($urandom_range(799), $urandom_range(524), 1'b1);
      total++;
      if (rgb !== 12'h000 || de_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold rgb=%h exp=000 de=%b exp=0", rgb, de_out);
      end
    end
    rst = 1'b1;
    step(320, 240, 1'b1);
    total++;
    if (rgb !== 12'h000 || de_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_1cyc rgb=%h exp=000 de=%b exp=0", rgb, de_out);
    end
    step(320, 240, 1'b1);
    total++;
    if (rgb !== 12'hFFF || de_out !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_2cyc rgb=%h exp=fff de=%b exp=1", rgb, de_out);
    end
  endtask

  // Shadows still hold reset positions here: paddles cover line 200.
  task automatic test_latency();
    for (int h = 0; h < 642; h++) begin
      step((h < 640) ? h : 0, 200, h < 640);
      total++;
      if (rgb !== lag_rgb || de_out !== lag_de) begin
        bad++;
        $display("FAIL latency h=%0d v=%0d rgb=%h exp=%h de=%b exp=%b",
                 lag_h, lag_v, rgb, lag_rgb, de_out, lag_de);
      end
    end
  endtask

  task automatic test_tearing();
    set_pos(320, 240, 24, 191, 603, 191);
    step(0, 480, 1'b0);
    sq_xpos = 10'd100;
    step(0, 100, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int h = 90; h < 342; h++) begin
        step(h, 245, 1'b1);
        total++;
        if (rgb !== lag_rgb || de_out !== lag_de) begin
          bad++;
          $display("FAIL tearing pass=%0d h=%0d v=%0d rgb=%h exp=%h de=%b exp=%b",
                   pass, lag_h, lag_v, rgb, lag_rgb, de_out, lag_de);
        end
      end
      step(0, 480, 1'b0);
    end
  endtask

  task automatic test_latch_capture();
    sq_xpos = 10'd400;
    step(1, 480, 1'b0);
    step(0, 479, 1'b0);
    sq_xpos = 10'd200;
    step(0, 480, 1'b0);
    sq_xpos = 10'd500;
    step(1, 480, 1'b0);
    for (int h = 190; h < 522; h++) begin
      step(h, 250, 1'b1);
      total++;
      if (rgb !== lag_rgb || de_out !== lag_de) begin
        bad++;
        $display("FAIL latch_capture h=%0d v=%0d rgb=%h exp=%h de=%b exp=%b",
                 lag_h, lag_v, rgb, lag_rgb, de_out, lag_de);
      end
    end
  endtask

  task automatic test_edge_clip();
    set_pos(635, 10, 24, 191, 603, 191);
    step(0, 480, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step((i < 15) ? 625 + i : i - 15, 12, 1'b1);
      total++;
      if (rgb !== lag_rgb || de_out !== lag_de) begin
        bad++;
        $display("FAIL edge_clip h=%0d v=%0d rgb=%h exp=%h de=%b exp=%b",
                 lag_h, lag_v, rgb, lag_rgb, de_out, lag_de);
      end
    end
  endtask

  task automatic test_blanking();
    set_pos(320, 240, 24, 191, 603, 191);
    step(0, 480, 1'b0);
    step(325, 245, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(320 + i, 240 + i, 1'b0);
      total++;
      if (rgb !== 12'h000 || de_out !== 1'b0) begin
        bad++;
        $display("FAIL blanking h=%0d v=%0d rgb=%h exp=000 de=%b exp=0",
                 lag_h, lag_v, rgb, de_out);
      end
    end
  endtask

  task automatic test_net();
    step(319, 5, 1'b1);
    step(319, 20, 1'b1);
    total++;
    if (rgb !== lag_rgb || de_out !== lag_de) begin
      bad++;
      $display("FAIL net v=5 rgb=%h exp=%h de=%b exp=%b", rgb, lag_rgb, de_out, lag_de);
    end
    step(320, 36, 1'b1);
    total++;
    if (rgb !== lag_rgb || de_out !== lag_de) begin
      bad++;
      $display("FAIL net v=20 rgb=%h exp=%h de=%b exp=%b", rgb, lag_rgb, de_out, lag_de);
    end
    step(0, 0, 1'b0);
    total++;
    if (rgb !== lag_rgb || de_out !== lag_de) begin
      bad++;
      $display("FAIL net v=36 h=320 rgb=%h exp=%h de=%b exp=%b", rgb, lag_rgb, de_out, lag_de);
    end
  endtask

  task automatic test_random();
    int h, v, sel;
    for (int i = 0; i < 3000; i++) begin
      if (i % 97 == 0) begin
        set_pos($urandom_range(660), $urandom_range(500), $urandom_range(660),
                $urandom_range(500), $urandom_range(660), $urandom_range(500));
      end
      sel = int'($urandom_range(9));
      // Bias pixels toward sprite edges so hits and near-misses are both common.
      case (sel)
        0: begin h = 0; v = 480; end
        1, 2: begin h = m_sq_x - 2 + int'($urandom_range(19)); v = m_sq_y - 2 + int'($urandom_range(19)); end
        3, 4: begin h = m_p1_x - 2 + int'($urandom_range(15)); v = m_p1_y - 2 + int'($urandom_range(99)); end
        5, 6: begin h = m_p2_x - 2 + int'($urandom_range(15)); v = m_p2_y - 2 + int'($urandom_range(99)); end
        default: begin h = int'($urandom_range(799)); v = int'($urandom_range(524)); end
      endcase
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      if (h > 1023) h = 1023;
      if (v > 1023) v = 1023;
      step(h, v, $urandom_range(7) != 0);
      total++;
      if (rgb !== lag_rgb || de_out !== lag_de) begin
        bad++;
        $display("FAIL random i=%0d h=%0d v=%0d rgb=%h exp=%h de=%b exp=%b",
                 i, lag_h, lag_v, rgb, lag_rgb, de_out, lag_de);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0;
    h_count = '0; v_count = '0; video_on = 1'b0;
    set_pos(320, 240, 24, 191, 603, 191);
    model_reset();
    cur_rgb = 12'h000; cur_de = 1'b0; lag_rgb = 12'h000; lag_de = 1'b0;
    cur_h = 0; cur_v = 0; lag_h = 0; lag_v = 0;
    test_reset();
    test_latency();
    test_tearing();
    test_latch_capture();
    test_edge_clip();
    test_blanking();
    test_net();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
